// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle sequencer: state encoding, error codes and
// instruction size.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF_REQ   = 3'd0,
    S_IF_WAIT  = 3'd1,
    S_ID       = 3'd2,
    S_EXE      = 3'd3,
    S_MEM_REQ  = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_WB       = 3'd6,
    S_HALT     = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_INST_TO  = 2'd1,
    ERR_DATA_TO  = 2'd2,
    ERR_MISALIGN = 2'd3
  } err_e;

  localparam int INST_BYTES = 4;

  // States in which the wait timer is allowed to run.
  function automatic logic is_bus_state(state_e s);
    return (s == S_IF_REQ) || (s == S_IF_WAIT) || (s == S_MEM_REQ) || (s == S_MEM_WAIT);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// SRAM-like instruction and data bus between the sequencer (master) and memory (slave).
interface multicycle_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    output inst_req, inst_addr, data_req, data_wr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  inst_req, inst_addr, data_req, data_wr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// Bus wait timer: counts enabled cycles since the last clear and flags the
// cycle in which the TIMEOUT-th enabled cycle is reached.
module multicycle_ctrl_wait_timer #(
  parameter int          W       = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds (cycles already spent), so the TIMEOUT-th cycle sees TIMEOUT-1.
  generate
    if (TIMEOUT > 0) begin : g_timeout_on
      assign expired = en && (cnt_q == W'(TIMEOUT - 1));
    end else begin : g_timeout_off
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer: owns PC, IR, load-data register,
// retire counter and the sticky halt on bus timeout or misaligned branch.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h1c000000),
  parameter int unsigned     TIMEOUT  = 255,
  parameter int              CNT_W    = 32
) (
  input  logic               clk,
  input  logic               resetn,
  multicycle_ctrl_if.master  bus,
  input  logic               dec_is_load,
  input  logic               dec_is_store,
  input  logic               dec_gr_we,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  pc,
  output logic [31:0]        ir,
  output logic [31:0]        mem_rdata_q,
  output logic               id_en,
  output logic               exe_en,
  output logic               rf_we,
  output logic [2:0]         state,
  output logic               halted,
  output logic [1:0]         err_code,
  output logic [CNT_W-1:0]   retired,
  output logic [ADDR_W-1:0]  debug_wb_pc
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  err_e                err_q, err_d;
  logic                start_q;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   wb_pc_q, wb_pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [31:0]         mem_rdata_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                tmr_clr, tmr_en, tmr_expired;

  // Timer restarts on entry to either request state and only runs while bus-bound.
  assign tmr_en  = start_q && is_bus_state(state_q);
  assign tmr_clr = (state_d != state_q) && ((state_d == S_IF_REQ) || (state_d == S_MEM_REQ));

  multicycle_ctrl_wait_timer #(
    .W       (TW),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (resetn),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    pc_d         = pc_q;
    wb_pc_d      = wb_pc_q;
    ir_d         = ir_q;
    mem_rdata_d  = mem_rdata_q;
    retired_d    = retired_q;
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    bus.data_wr  = 1'b0;
    id_en        = 1'b0;
    exe_en       = 1'b0;
    rf_we        = 1'b0;

    case (state_q)
      S_IF_REQ: begin
        bus.inst_req = start_q;
        if (start_q) begin
          if (tmr_expired) begin
            state_d = S_HALT;
            err_d   = ERR_INST_TO;
          end else if (bus.inst_addr_ok) begin
            state_d = S_IF_WAIT;
          end
        end
      end
      // A data_ok coinciding with expiry completes the access normally.
      S_IF_WAIT: begin
        if (bus.inst_data_ok) begin
          ir_d    = bus.inst_rdata;
          state_d = S_ID;
        end else if (tmr_expired) begin
          state_d = S_HALT;
          err_d   = ERR_INST_TO;
        end
      end
      S_ID: begin
        id_en   = 1'b1;
        state_d = S_EXE;
      end
      S_EXE: begin
        exe_en  = 1'b1;
        state_d = (dec_is_load || dec_is_store) ? S_MEM_REQ : S_WB;
      end
      S_MEM_REQ: begin
        bus.data_req = 1'b1;
        bus.data_wr  = dec_is_store;
        if (tmr_expired) begin
          state_d = S_HALT;
          err_d   = ERR_DATA_TO;
        end else if (bus.data_addr_ok) begin
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (bus.data_data_ok) begin
          if (dec_is_load) begin
            mem_rdata_d = bus.data_rdata;
          end
          state_d = S_WB;
        end else if (tmr_expired) begin
          state_d = S_HALT;
          err_d   = ERR_DATA_TO;
        end
      end
      // The faulting instruction still retires; only the PC redirect is suppressed.
      S_WB: begin
        rf_we     = dec_gr_we && !dec_is_store;
        wb_pc_d   = pc_q;
        retired_d = retired_q + CNT_W'(1);
        if (br_taken && (br_target[1:0] != 2'b00)) begin
          state_d = S_HALT;
          err_d   = ERR_MISALIGN;
        end else begin
          pc_d    = br_taken ? br_target : (pc_q + ADDR_W'(INST_BYTES));
          state_d = S_IF_REQ;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IF_REQ;
      err_q       <= ERR_NONE;
      start_q     <= 1'b0;
      pc_q        <= RESET_PC;
      wb_pc_q     <= '0;
      ir_q        <= '0;
      mem_rdata_q <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      start_q     <= 1'b1;
      pc_q        <= pc_d;
      wb_pc_q     <= wb_pc_d;
      ir_q        <= ir_d;
      mem_rdata_q <= mem_rdata_d;
      retired_q   <= retired_d;
    end
  end

  assign bus.inst_addr = pc_q;
  assign pc            = pc_q;
  assign ir            = ir_q;
  assign state         = state_q;
  assign halted        = (state_q == S_HALT);
  assign err_code      = err_q;
  assign retired       = retired_q;
  assign debug_wb_pc   = wb_pc_q;

endmodule
